fifo_uart_tx: RTL and testbench

//   Read-side drain for the 8-bit asynchronous FIFO. Runs entirely in the FIFO read clock domain.

---
 rtl/fifo_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: read-side drain of the 8-bit asynchronous FIFO, in the FIFO
// read clock domain. Pops one byte at a time and sends it as an 8N1/8E1/8O1
// UART frame. The line idles high while the FIFO is empty or the block is
// disabled.
//
// Ports
//   clk         FIFO read clock
//   rst         synchronous reset, active low
//   enable      1 = start new frames while data is available
//   fifo_empty  FIFO empty flag
//   fifo_re     FIFO read enable, one-cycle pulse per byte
//   fifo_rdata  FIFO read data, valid the cycle after fifo_re
//   tx          serial line, idle high
//   busy        1 whenever the FSM is not in IDLE
//   frame_done  one-cycle pulse in the first IDLE cycle after the last stop bit
//
// State   | Meaning
// --------+----------------------------------------------------------
// IDLE    | line high; waits for enable and a non-empty FIFO
// POP     | fifo_re pulse
// LATCH   | capture fifo_rdata into the shift register and compute parity
// START   | start bit (low) for CLK_DIV cycles
// DATA    | DW data bits, LSB first, CLK_DIV cycles each
// PARITY  | parity bit for CLK_DIV cycles (only when PARITY_EN = 1)
// STOP    | line high for STOP_BITS * CLK_DIV cycles

module fifo_uart_tx #(
  parameter int DW         = 8,
  parameter int CLK_DIV    = 868,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_rdata,
  output logic          tx,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [BW-1:0] bit_idx;
  logic [DW-1:0] shreg;
  logic          par_bit;

  // Outputs are assigned together with the state they belong to, so tx, busy
  // and fifo_re line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      fifo_re    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_re    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state   <= S_POP;
            fifo_re <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_POP: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          shreg    <= fifo_rdata;
          par_bit  <= (^fifo_rdata) ^ PAR_ODD_BIT;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              // shreg[0] always holds the bit on the line; the next one is [1]
              bit_idx <= bit_idx + BW'(1);
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          // bit_idx counts stop-bit periods here
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx    <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with three instances at CLK_DIV=4, DW=8:
//   d0: 8N1, d1: 8E1 with two stop bits, d2: 8O1.
// Each instance is fed by a simple FIFO model; received frames are decoded
// from the tx line and compared with frames built from the byte by UART rules.

module tb_fifo_uart_tx;

  localparam int CD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enable;
  logic [2:0] fifo_empty;
  logic [2:0] fifo_re;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] frame_done;
  logic [7:0] fifo_rdata [3];

  logic [7:0] mem [3][64];
  int wr_ptr [3];
  int rd_ptr [3];
  int re_cnt [3];
  int done_cnt [3];
  int busy_run [3];
  int busy_len [3];
  int pop_empty;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_uart_tx #(.DW(8), .CLK_DIV(CD), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) d0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]), .fifo_re(fifo_re[0]),
    .fifo_rdata(fifo_rdata[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  fifo_uart_tx #(.DW(8), .CLK_DIV(CD), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) d1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]), .fifo_re(fifo_re[1]),
    .fifo_rdata(fifo_rdata[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  fifo_uart_tx #(.DW(8), .CLK_DIV(CD), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) d2 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[2]), .fifo_re(fifo_re[2]),
    .fifo_rdata(fifo_rdata[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2]));

  // FIFO model: read data appears the cycle after fifo_re
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fifo_re[k] === 1'b1) begin
        re_cnt[k] <= re_cnt[k] + 1;
        if (rd_ptr[k] == wr_ptr[k]) pop_empty <= pop_empty + 1;
        fifo_rdata[k] <= mem[k][rd_ptr[k] % 64];
        rd_ptr[k]     <= rd_ptr[k] + 1;
      end
      if (frame_done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  always_comb begin
    fifo_empty = '0;
    for (int k = 0; k < 3; k++) fifo_empty[k] = (rd_ptr[k] == wr_ptr[k]);
  end

  // length of the most recent busy-high run, in cycles
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy[k] === 1'b1) begin
        busy_run[k] <= busy_run[k] + 1;
      end else if (busy_run[k] != 0) begin
        busy_len[k] <= busy_run[k];
        busy_run[k] <= 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nbits(input int k);
    case (k)
      0:       return 10;
      1:       return 12;
      default: return 11;
    endcase
  endfunction

  function automatic int par_en(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic int par_odd(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  // Frame bits in line order (index 0 = start bit); unused upper bits stay 1.
  function automatic logic [11:0] model_frame(input int k, input logic [7:0] d);
    logic [11:0] f;
    int p;
    f = '1;
    f[0] = 1'b0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      f[p] = d[i];
      p++;
    end
    if (par_en(k) != 0) begin
      // even parity makes the total count of ones even; odd parity makes it odd
      f[p] = (($countones(d) + par_odd(k)) % 2) == 1;
    end
    return f;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr_ptr[k] % 64] = b;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  // Called at a negedge. Counts idle-high samples before the start bit, then
  // reads nbits(k) segments of CD cycles, each required to be constant.
  // Returns at the negedge of the cycle following the last stop cycle.
  task automatic capture(input int k, output logic [11:0] bits, output bit ok, output int gap);
    int t;
    logic v;
    bits = '1;
    ok = 1'b1;
    gap = 0;
    t = 0;
    while (tx[k] !== 1'b0) begin
      if (t >= 400) begin
        ok = 1'b0;
        return;
      end
      gap++;
      t++;
      @(negedge clk);
    end
    for (int b = 0; b < nbits(k); b++) begin
      v = tx[k];
      for (int c = 0; c < CD; c++) begin
        if (tx[k] !== v) ok = 1'b0;
        @(negedge clk);
      end
      bits[b] = v;
    end
  endtask

  task automatic expect_frame(input int k, input logic [7:0] d, input string nm,
                              output logic [11:0] got);
    bit ok;
    int gap;
    capture(k, got, ok, gap);
    check({nm, " start/segments"}, 32'(ok), 32'd1);
    check({nm, " frame"}, 32'(got), 32'(model_frame(k, d)));
    check({nm, " idle gap"}, gap, 3);
    check({nm, " frame_done"}, 32'(frame_done[k]), 32'd1);
    check({nm, " busy after"}, 32'(busy[k]), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [11:0] got;
    logic [7:0]  rb [4];
    int re0;
    int cnt;
    int k;
    int n;

    vt[0] = '{8'hA5, 1'b0, 1'b1};
    vt[1] = '{8'h07, 1'b1, 1'b0};
    vt[2] = '{8'h00, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 1'b0, 1'b1};
    vt[4] = '{8'h80, 1'b1, 1'b0};

    pop_empty = 0;
    for (int i = 0; i < 3; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
      re_cnt[i] = 0;
      done_cnt[i] = 0;
      busy_run[i] = 0;
      busy_len[i] = 0;
      fifo_rdata[i] = '0;
    end

    // reset held with data available and enable high
    rst = 1'b0;
    enable = 1'b1;
    push(0, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset outputs d0", 32'({tx[0], fifo_re[0], busy[0], frame_done[0]}), 32'b1000);
    end
    check("reset tx all", 32'(tx), 32'b111);
    rst = 1'b1;

    // single 0xA5 frame
    expect_frame(0, 8'hA5, "a5 d0", got);
    check("a5 line bits", 32'(got[9:0]), 32'b11_0100_1010);
    @(negedge clk);
    check("a5 busy length", busy_len[0], 42);
    check("a5 fifo_re pulses", re_cnt[0], 1);

    // table: each byte through all three framings
    for (int i = 0; i < 5; i++) begin
      push(0, vt[i].data);
      expect_frame(0, vt[i].data, "tbl d0", got);
      push(1, vt[i].data);
      expect_frame(1, vt[i].data, "tbl d1", got);
      check("tbl even parity bit", 32'(got[9]), 32'(vt[i].par_even));
      push(2, vt[i].data);
      expect_frame(2, vt[i].data, "tbl d2", got);
      check("tbl odd parity bit", 32'(got[9]), 32'(vt[i].par_odd));
    end

    // three queued bytes, two stop bits: back-to-back frames
    re0 = re_cnt[1];
    push(1, 8'h3C);
    push(1, 8'hC1);
    push(1, 8'h5E);
    expect_frame(1, 8'h3C, "b2b f1", got);
    expect_frame(1, 8'hC1, "b2b f2", got);
    expect_frame(1, 8'h5E, "b2b f3", got);
    @(negedge clk);
    check("b2b fifo_re pulses", re_cnt[1] - re0, 3);

    // enable dropped during DATA of byte 1 with two bytes queued
    re0 = re_cnt[0];
    push(0, 8'h96);
    push(0, 8'h2B);
    fork
      expect_frame(0, 8'h96, "en drop", got);
      begin
        repeat (14) @(negedge clk);
        enable = 1'b0;
      end
    join
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx[0] === 1'b1 && fifo_re[0] === 1'b0) cnt++;
      @(negedge clk);
    end
    check("en drop idle cycles", cnt, 60);
    check("en drop fifo_re pulses", re_cnt[0] - re0, 1);

    // reset during DATA bit 3 of byte 0x2B; next byte 0xD4 must follow
    push(0, 8'hD4);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("rst mid tx bit3", 32'(tx[0]), 32'(1'b1));
    rst = 1'b0;
    @(negedge clk);
    check("rst mid tx", 32'(tx[0]), 32'd1);
    check("rst mid busy", 32'(busy[0]), 32'd0);
    check("rst mid fifo_re", 32'(fifo_re[0]), 32'd0);
    rst = 1'b1;
    expect_frame(0, 8'hD4, "after rst", got);

    // random bursts on random instances
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        rb[i] = 8'($urandom);
        push(k, rb[i]);
      end
      for (int i = 0; i < n; i++) expect_frame(k, rb[i], "rand", got);
    end

    repeat (3) @(negedge clk);
    check("pop while empty", pop_empty, 0);
    check("d0 done vs pops", done_cnt[0], re_cnt[0] - 1);
    check("d1 done vs pops", done_cnt[1], re_cnt[1]);
    check("d2 done vs pops", done_cnt[2], re_cnt[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
